// File: rtl/sddac_mod2_stereo_pkg.sv
// rtl/sddac_mod2_stereo_pkg.sv - shared constants and saturating add for the sddac modulator
package sddac_mod2_stereo_pkg;

  localparam int SDDAC_SAMPLE_W  = 18;
  localparam int SDDAC_FS        = 2**17;
  localparam int SDDAC_MAX_ACC_W = 32;
  localparam int SDDAC_SUM_W     = SDDAC_MAX_ACC_W + 2;

  // Wide enough to hold any integrator sum without wrapping before the clamp.
  typedef logic signed [SDDAC_SUM_W-1:0] sddac_sum_t;

  // Adds two operands and clamps the result to the signed range of an acc_w-bit integrator.
  function automatic sddac_sum_t sddac_sat_add(input sddac_sum_t a, input sddac_sum_t b,
                                               input int acc_w);
    sddac_sum_t sum;
    sddac_sum_t hi;
    sddac_sum_t lo;
    sum = a + b;
    hi  = (sddac_sum_t'(1) <<< (acc_w - 1)) - sddac_sum_t'(1);
    lo  = -(sddac_sum_t'(1) <<< (acc_w - 1));
    if (sum > hi) return hi;
    if (sum < lo) return lo;
    return sum;
  endfunction

endpackage

// File: rtl/sddac_mod2_stereo_ch.sv
// rtl/sddac_mod2_stereo_ch.sv - one channel of the 2nd-order 1-bit delta-sigma modulator
module sddac_mod2_ch
  import sddac_mod2_stereo_pkg::*;
#(
  parameter int ACC_W = 24
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             en,
  input  logic                             tick,
  input  logic                             ld,
  input  logic signed [SDDAC_SAMPLE_W-1:0] din,
  input  logic                             ovl_clr,
  output logic                             dac_out,
  output logic                             ovl
);

  logic signed [SDDAC_SAMPLE_W-1:0] hold;
  logic signed [ACC_W-1:0]          v1;
  logic signed [ACC_W-1:0]          v2;
  sddac_sum_t                       x;
  sddac_sum_t                       fb;
  sddac_sum_t                       v1_sum;
  sddac_sum_t                       v1_sat;
  sddac_sum_t                       v2_sum;
  sddac_sum_t                       v2_sat;
  logic                             clip;

  // Next integrator values for the pending tick; a clamp is any sum the saturation altered.
  always_comb begin
    x      = sddac_sum_t'(hold);
    fb     = dac_out ? sddac_sum_t'(SDDAC_FS) : -sddac_sum_t'(SDDAC_FS);
    v1_sum = sddac_sum_t'(v1) + x - fb;
    v1_sat = sddac_sat_add(sddac_sum_t'(v1), x - fb, ACC_W);
    v2_sum = sddac_sum_t'(v2) + v1_sat - fb;
    v2_sat = sddac_sat_add(sddac_sum_t'(v2), v1_sat - fb, ACC_W);
    clip   = (v1_sum != v1_sat) || (v2_sum != v2_sat);
  end

  // Zero-order hold; a capture on a tick cycle is only seen by the following tick.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)   hold <= '0;
    else if (ld) hold <= din;
  end

  // Integrators and bitstream advance once per tick; disabled ticks clear and toggle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      v1      <= '0;
      v2      <= '0;
      dac_out <= 1'b0;
    end else if (tick) begin
      if (en) begin
        v1      <= v1_sat[ACC_W-1:0];
        v2      <= v2_sat[ACC_W-1:0];
        dac_out <= ~v2_sat[SDDAC_SUM_W-1];
      end else begin
        v1      <= '0;
        v2      <= '0;
        dac_out <= ~dac_out;
      end
    end
  end

  // Sticky overload flag; a new clamp outranks a simultaneous clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                    ovl <= 1'b0;
    else if (tick && en && clip)  ovl <= 1'b1;
    else if (ovl_clr)             ovl <= 1'b0;
  end

endmodule

// File: rtl/sddac_mod2_stereo.sv
// rtl/sddac_mod2_stereo.sv - stereo 2nd-order delta-sigma DAC modulator with tick and request pacing
module sddac_mod2_stereo
  import sddac_mod2_stereo_pkg::*;
#(
  parameter int OSR_DIV   = 16,
  parameter int REQ_TICKS = 32,
  parameter int ACC_W     = 24
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             en,
  input  logic                             sample_in_rdy,
  input  logic signed [SDDAC_SAMPLE_W-1:0] sample_in_l,
  input  logic signed [SDDAC_SAMPLE_W-1:0] sample_in_r,
  output logic                             sample_req,
  output logic                             mod_tick,
  output logic                             dac_out_l,
  output logic                             dac_out_r,
  input  logic                             ovl_clr,
  output logic                             ovl_l,
  output logic                             ovl_r
);

  localparam int TCNT_W = $clog2(OSR_DIV);
  localparam int RCNT_W = $clog2(REQ_TICKS);
  localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(OSR_DIV - 1);
  localparam logic [RCNT_W-1:0] RCNT_LAST = RCNT_W'(REQ_TICKS - 1);

  logic [TCNT_W-1:0] tcnt;
  logic [RCNT_W-1:0] rcnt;
  logic              tick;
  logic              rwrap;

  assign tick  = (tcnt == TCNT_LAST);
  assign rwrap = (rcnt == RCNT_LAST);

  // Free-running tick divider, independent of en.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)     tcnt <= '0;
    else if (tick) tcnt <= '0;
    else           tcnt <= tcnt + 1'b1;
  end

  // Counts ticks between upstream sample requests.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)      rcnt <= '0;
    else if (tick)  rcnt <= rwrap ? '0 : rcnt + 1'b1;
  end

  // Strobes registered so they line up with the new dac_out values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mod_tick   <= 1'b0;
      sample_req <= 1'b0;
    end else begin
      mod_tick   <= tick;
      sample_req <= tick && rwrap;
    end
  end

  sddac_mod2_ch #(.ACC_W(ACC_W)) u_ch_l (
    .clk     (clk),
    .reset   (reset),
    .en      (en),
    .tick    (tick),
    .ld      (sample_in_rdy),
    .din     (sample_in_l),
    .ovl_clr (ovl_clr),
    .dac_out (dac_out_l),
    .ovl     (ovl_l)
  );

  sddac_mod2_ch #(.ACC_W(ACC_W)) u_ch_r (
    .clk     (clk),
    .reset   (reset),
    .en      (en),
    .tick    (tick),
    .ld      (sample_in_rdy),
    .din     (sample_in_r),
    .ovl_clr (ovl_clr),
    .dac_out (dac_out_r),
    .ovl     (ovl_r)
  );

endmodule

// File: tb/tb_sddac_mod2_stereo.sv
// tb/tb_sddac_mod2_stereo.sv - randomized and directed checks of the stereo delta-sigma modulator
module tb_sddac_mod2_stereo;

  localparam int     OSR = 16;
  localparam int     REQ = 32;
  localparam longint FS  = 131072;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic               en = 1'b0;
  logic               sample_in_rdy = 1'b0;
  logic signed [17:0] sample_in_l = '0;
  logic signed [17:0] sample_in_r = '0;
  logic               ovl_clr = 1'b0;

  logic sample_req, mod_tick, dac_out_l, dac_out_r, ovl_l, ovl_r;
  logic sample_req20, mod_tick20, dac20_l, dac20_r, ovl20_l, ovl20_r;

  sddac_mod2_stereo dut (
    .clk(clk), .reset(reset), .en(en), .sample_in_rdy(sample_in_rdy),
    .sample_in_l(sample_in_l), .sample_in_r(sample_in_r),
    .sample_req(sample_req), .mod_tick(mod_tick),
    .dac_out_l(dac_out_l), .dac_out_r(dac_out_r),
    .ovl_clr(ovl_clr), .ovl_l(ovl_l), .ovl_r(ovl_r)
  );

  sddac_mod2_stereo #(.ACC_W(20)) dut20 (
    .clk(clk), .reset(reset), .en(en), .sample_in_rdy(sample_in_rdy),
    .sample_in_l(sample_in_l), .sample_in_r(sample_in_r),
    .sample_req(sample_req20), .mod_tick(mod_tick20),
    .dac_out_l(dac20_l), .dac_out_r(dac20_r),
    .ovl_clr(ovl_clr), .ovl_l(ovl20_l), .ovl_r(ovl20_r)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input longint got, input longint exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Reference model: index [inst][ch], inst 0 = ACC_W 24, inst 1 = ACC_W 20.
  longint m_v1[2][2];
  longint m_v2[2][2];
  longint m_hold[2];
  bit     m_dac[2][2];
  bit     m_ovl[2][2];
  bit     m_tick;
  bit     m_req;
  longint n;

  function automatic int accw(input int i);
    return (i == 0) ? 24 : 20;
  endfunction

  function automatic longint clampv(input longint s, input int w, output bit hit);
    longint lim;
    lim = longint'(1) << (w - 1);
    hit = 1'b1;
    if (s > lim - 1) return lim - 1;
    if (s < -lim) return -lim;
    hit = 1'b0;
    return s;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      for (int c = 0; c < 2; c++) begin
        m_v1[i][c] = 0; m_v2[i][c] = 0; m_dac[i][c] = 0; m_ovl[i][c] = 0;
      end
      m_hold[i] = 0;
    end
    m_tick = 0; m_req = 0; n = 0;
  endtask

  // Effect of the coming rising edge, given the inputs currently driven.
  task automatic model_step();
    bit tick_now, hit1, hit2, clip;
    longint x, fb;
    tick_now = (n % OSR) == OSR - 1;
    m_tick = tick_now;
    m_req  = tick_now && (((n + 1) % (OSR * REQ)) == 0);
    for (int i = 0; i < 2; i++) begin
      for (int c = 0; c < 2; c++) begin
        clip = 1'b0;
        if (tick_now) begin
          if (en) begin
            x  = m_hold[c];
            fb = m_dac[i][c] ? FS : -FS;
            m_v1[i][c] = clampv(m_v1[i][c] + x - fb, accw(i), hit1);
            m_v2[i][c] = clampv(m_v2[i][c] + m_v1[i][c] - fb, accw(i), hit2);
            m_dac[i][c] = (m_v2[i][c] >= 0);
            clip = hit1 || hit2;
          end else begin
            m_v1[i][c] = 0;
            m_v2[i][c] = 0;
            m_dac[i][c] = !m_dac[i][c];
          end
        end
        if (clip) m_ovl[i][c] = 1'b1;
        else if (ovl_clr) m_ovl[i][c] = 1'b0;
      end
    end
    if (sample_in_rdy) begin
      m_hold[0] = longint'(sample_in_l);
      m_hold[1] = longint'(sample_in_r);
    end
    n++;
  endtask

  function automatic logic [11:0] got_vec();
    return {mod_tick, sample_req, dac_out_l, dac_out_r, ovl_l, ovl_r,
            mod_tick20, sample_req20, dac20_l, dac20_r, ovl20_l, ovl20_r};
  endfunction

  function automatic logic [11:0] exp_vec();
    return {m_tick, m_req, m_dac[0][0], m_dac[0][1], m_ovl[0][0], m_ovl[0][1],
            m_tick, m_req, m_dac[1][0], m_dac[1][1], m_ovl[1][0], m_ovl[1][1]};
  endfunction

  // One clock: inputs are already driven at the preceding falling edge.
  task automatic cycle();
    model_step();
    @(negedge clk);
    check_eq("outs", longint'(got_vec()), longint'(exp_vec()));
  endtask

  task automatic align_to_tick();
    for (int k = 0; k < OSR && (n % OSR) != OSR - 1; k++) cycle();
  endtask

  initial begin
    int first, req1, req2, ones_l, ones_r, bad, sum8, seen;
    bit bits_l[$];
    bit prev;
    longint fbv, exp1, exp2;

    model_reset();
    repeat (3) @(negedge clk);
    check_eq("reset_outs", longint'(got_vec()), 0);

    // Release and measure tick / request pacing with en low.
    reset = 1'b0;
    first = 0; req1 = 0; req2 = 0;
    for (int k = 1; k <= 1100; k++) begin
      cycle();
      if (mod_tick && first == 0) first = k;
      if (sample_req) begin
        if (req1 == 0) req1 = k;
        else if (req2 == 0) req2 = k;
      end
    end
    check_eq("first_tick", first, 16);
    check_eq("req_first", req1, 512);
    check_eq("req_second", req2, 1024);

    // Zero input: half density, settles into a balanced limit cycle.
    en = 1'b1;
    ones_l = 0; ones_r = 0;
    for (int k = 0; k < 1024 * OSR; k++) begin
      cycle();
      if (mod_tick) begin
        bits_l.push_back(dac_out_l);
        ones_l += int'(dac_out_l);
        ones_r += int'(dac_out_r);
      end
    end
    check_eq("zero_ticks", bits_l.size(), 1024);
    check_eq("zero_density_l", (ones_l >= 510 && ones_l <= 514), 1);
    check_eq("zero_density_r", (ones_r >= 510 && ones_r <= 514), 1);
    bad = 0;
    for (int k = 8; k + 8 <= bits_l.size(); k++) begin
      sum8 = 0;
      for (int j = 0; j < 8; j++) sum8 += int'(bits_l[k + j]);
      if (sum8 != 4) bad++;
    end
    check_eq("zero_settle", bad, 0);
    check_eq("zero_ovl", longint'({ovl_l, ovl_r}), 0);

    // Half-scale inputs of opposite sign.
    sample_in_l = 18'sd65536; sample_in_r = -18'sd65536; sample_in_rdy = 1'b1;
    cycle();
    sample_in_rdy = 1'b0;
    ones_l = 0; ones_r = 0;
    for (int k = 0; k < 2048 * OSR; k++) begin
      cycle();
      if (mod_tick) begin
        ones_l += int'(dac_out_l);
        ones_r += int'(dac_out_r);
      end
    end
    check_eq("half_density_l", (ones_l >= 1532 && ones_l <= 1540), 1);
    check_eq("half_density_r", (ones_r >= 508 && ones_r <= 516), 1);
    check_eq("half_ovl", longint'({ovl_l, ovl_r}), 0);

    // Negative full scale on the narrow instance drives it into saturation.
    sample_in_l = -18'sd131072; sample_in_r = '0; sample_in_rdy = 1'b1;
    cycle();
    sample_in_rdy = 1'b0;
    repeat (64 * OSR) cycle();
    check_eq("ovl20_l_set", ovl20_l, 1);
    check_eq("ovl20_r_quiet", ovl20_r, 0);
    align_to_tick();
    ovl_clr = 1'b1;
    cycle();
    ovl_clr = 1'b0;
    check_eq("clr_set_wins", ovl20_l, 1);

    sample_in_l = '0; sample_in_rdy = 1'b1;
    cycle();
    sample_in_rdy = 1'b0;
    repeat (64 * OSR) cycle();
    if ((n % OSR) == OSR - 1) cycle();
    ovl_clr = 1'b1;
    cycle();
    ovl_clr = 1'b0;
    check_eq("ovl20_cleared", ovl20_l, 0);
    seen = 0;
    for (int k = 0; k < 256 * OSR; k++) begin
      cycle();
      if (ovl20_l) seen = 1;
    end
    check_eq("ovl20_stays_clear", seen, 0);

    // Capture coincident with a tick: that update still uses the old hold.
    align_to_tick();
    fbv  = m_dac[0][0] ? FS : -FS;
    exp1 = m_v1[0][0] + 0 - fbv;
    sample_in_l = 18'sd40000; sample_in_rdy = 1'b1;
    cycle();
    sample_in_rdy = 1'b0;
    check_eq("hold_old", longint'(dut.u_ch_l.v1), exp1);
    fbv  = m_dac[0][0] ? FS : -FS;
    exp2 = exp1 + 40000 - fbv;
    repeat (OSR) cycle();
    check_eq("hold_new", longint'(dut.u_ch_l.v1), exp2);

    // Random traffic against the model.
    for (int k = 0; k < 3000; k++) begin
      sample_in_rdy = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 3) == 0) sample_in_l = 18'($urandom_range(0, 262143));
      else sample_in_l = 18'(int'($urandom_range(0, 65535)) - 32768);
      if ($urandom_range(0, 3) == 0) sample_in_r = 18'($urandom_range(0, 262143));
      else sample_in_r = 18'(int'($urandom_range(0, 65535)) - 32768);
      if ($urandom_range(0, 199) == 0) en = ~en;
      ovl_clr = ($urandom_range(0, 49) == 0);
      cycle();
    end
    sample_in_rdy = 1'b0; ovl_clr = 1'b0;

    // en dropped mid-run: alternating idle pattern with cleared integrators.
    en = 1'b1;
    repeat (5 * OSR) cycle();
    en = 1'b0;
    prev = dac_out_l;
    for (int k = 0; k < 8 * OSR; k++) begin
      cycle();
      if (mod_tick) begin
        check_eq("idle_toggle", dac_out_l, !prev);
        prev = dac_out_l;
        check_eq("idle_int", longint'({dut.u_ch_l.v1, dut.u_ch_l.v2}), 0);
      end
    end

    // Reset asserted between edges mid tick-period.
    en = 1'b1;
    repeat (3 * OSR) cycle();
    for (int k = 0; k < OSR && (n % OSR) != 7; k++) cycle();
    #2 reset = 1'b1;
    #1;
    model_reset();
    check_eq("reset_async_outs", longint'(got_vec()), 0);
    check_eq("reset_async_v1", longint'(dut.u_ch_l.v1), 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    first = 0;
    for (int k = 1; k <= 20; k++) begin
      cycle();
      if (mod_tick && first == 0) first = k;
    end
    check_eq("tick_after_reset", first, 16);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
